// File: rtl/nd_pkg.sv
// Purpose : shared types and constants for the USB non-data packet writer.
// Latency : n/a (types, constants and a pure helper function only).
// Backpr. : n/a.
package nd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // PID type field, taken from PID bits [1:0]
    localparam logic [1:0] PID_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_TOKEN     = 2'b01;
    localparam logic [1:0] PID_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_DATA      = 2'b11;

    // Register contents after an error-free token (data + CRC) has been shifted through
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    // The upper nibble of a PID byte is the one's complement of the lower nibble
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[3:0] == ~pid[7:4];
    endfunction

endpackage

// File: rtl/nd_crc5.sv
// Purpose : CRC5 residual check over the two token payload bytes.
// Latency : purely combinational.
// Backpr. : none.
// Ports   : data        - {byte2, byte1}; bit 0 is the first bit on the wire
//           residual_ok - high when the CRC5 register ends at the good residual
module nd_crc5
    import nd_pkg::*;
(
    input  logic [15:0] data,
    output logic        residual_ok
);

    logic [4:0] crc;
    logic       fb;

    // Serial LFSR, poly x^5+x^2+1, seeded to all ones, fed LSB first.
    // Feeding the received CRC bits as well leaves a fixed residual when intact.
    always_comb begin
        crc = 5'b11111;
        fb  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fb  = data[i] ^ crc[4];
            crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        residual_ok = (crc == CRC5_RESIDUAL);
    end

endmodule

// File: rtl/nd_pkt_writer.sv
// Purpose : validates received token/handshake packets and copies them whole into the non-data FIFO.
// Latency : first FIFO write the cycle after rx_eop; a 3-byte token finishes in 3 cycles.
// Backpr. : full stalls the write burst with the buffered packet held; rx is not backpressured.
// Ports   : clk, n_rst (sync, active high); rx_data/rx_valid/rx_eop/rx_error from the receiver;
//           full, w_enable, w_data to the FIFO write side; pkt_done/pkt_drop/data_pkt status pulses.
module nd_pkt_writer
    import nd_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_eop,
    input  logic       rx_error,
    input  logic       full,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       pkt_done,
    output logic       pkt_drop,
    output logic       data_pkt
);

    state_t     state_q, state_d;
    logic [7:0] pid_q, pid_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       drop_q, drop_d;
    logic       ovr_q, ovr_d;
    logic       eops_q, eops_d;
    logic       pkt_drop_q, pkt_drop_d;
    logic       data_pkt_q, data_pkt_d;

    logic       crc_ok;
    logic       pkt_pass;
    logic       wr_en;
    logic       done;
    logic [7:0] wr_byte;
    logic       ovr_now;
    logic       eop_now;

    nd_crc5 u_crc5 (
        .data        ({b2_q, b1_q}),
        .residual_ok (crc_ok)
    );

    assign pkt_pass = ((pid_q[1:0] == PID_TOKEN) && (cnt_q == 2'd3) && crc_ok) ||
                      ((pid_q[1:0] == PID_HANDSHAKE) && (cnt_q == 2'd1));

    always_comb begin
        case (idx_q)
            2'd0:    wr_byte = pid_q;
            2'd1:    wr_byte = b1_q;
            default: wr_byte = b2_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        ovr_d      = ovr_q;
        eops_d     = eops_q;
        pkt_drop_d = 1'b0;
        data_pkt_d = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        ovr_now    = 1'b0;
        eop_now    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_error) begin
                    state_d = ST_DISCARD;
                    drop_d  = 1'b1;
                end else if (rx_valid) begin
                    pid_d = rx_data;
                    cnt_d = 2'd1;
                    if (!pid_ok(rx_data)) begin
                        state_d = ST_DISCARD;
                        drop_d  = 1'b1;
                    end else if (rx_data[1:0] == PID_DATA) begin
                        // Data packets belong to another path: flag them, swallow silently
                        state_d    = ST_DISCARD;
                        drop_d     = 1'b0;
                        data_pkt_d = 1'b1;
                    end else if (rx_data[1:0] == PID_SPECIAL) begin
                        state_d = ST_DISCARD;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                if (rx_error) begin
                    state_d = ST_DISCARD;
                    drop_d  = 1'b1;
                end else if (rx_valid) begin
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DISCARD;
                        drop_d  = 1'b1;
                    end else begin
                        if (cnt_q == 2'd1) b1_d = rx_data;
                        else               b2_d = rx_data;
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (rx_eop) begin
                    if (pkt_pass) begin
                        state_d = ST_WRITE;
                        idx_d   = 2'd0;
                        ovr_d   = 1'b0;
                        eops_d  = 1'b0;
                    end else begin
                        state_d    = ST_IDLE;
                        pkt_drop_d = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                // Include this cycle's inputs so a collision on the last write is not lost
                ovr_now = ovr_q | rx_valid;
                eop_now = eops_q | rx_eop;
                ovr_d   = ovr_now;
                eops_d  = eop_now;
                if (!full) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == cnt_q - 2'd1) begin
                        done = 1'b1;
                        if (!ovr_now) begin
                            state_d = ST_IDLE;
                        end else if (eop_now) begin
                            // The overrunning packet already ended: report it now
                            state_d    = ST_IDLE;
                            pkt_drop_d = 1'b1;
                        end else begin
                            state_d = ST_DISCARD;
                            drop_d  = 1'b1;
                        end
                    end
                end
            end

            ST_DISCARD: begin
                if (rx_eop) begin
                    state_d    = ST_IDLE;
                    pkt_drop_d = drop_q;
                    drop_d     = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= ST_IDLE;
            pid_q      <= 8'h00;
            b1_q       <= 8'h00;
            b2_q       <= 8'h00;
            cnt_q      <= 2'd0;
            idx_q      <= 2'd0;
            drop_q     <= 1'b0;
            ovr_q      <= 1'b0;
            eops_q     <= 1'b0;
            pkt_drop_q <= 1'b0;
            data_pkt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            ovr_q      <= ovr_d;
            eops_q     <= eops_d;
            pkt_drop_q <= pkt_drop_d;
            data_pkt_q <= data_pkt_d;
        end
    end

    // Outputs are held low while reset is asserted so an interrupted burst stops at once
    assign w_enable = wr_en & ~n_rst;
    assign w_data   = ((state_q == ST_WRITE) && !n_rst) ? wr_byte : 8'h00;
    assign pkt_done = done & ~n_rst;
    assign pkt_drop = pkt_drop_q & ~n_rst;
    assign data_pkt = data_pkt_q & ~n_rst;

endmodule

// File: tb/tb_nd_pkt_writer.sv
// Purpose : directed table-driven bench for nd_pkt_writer plus a reset-mid-write sequence.
// Latency : inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpr. : full is driven from the vector table.
module tb_nd_pkt_writer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_eop, rx_error, full;
    logic       w_enable;
    logic [7:0] w_data;
    logic       pkt_done, pkt_drop, data_pkt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nd_pkt_writer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_eop   (rx_eop),
        .rx_error (rx_error),
        .full     (full),
        .w_enable (w_enable),
        .w_data   (w_data),
        .pkt_done (pkt_done),
        .pkt_drop (pkt_drop),
        .data_pkt (data_pkt)
    );

    // ctl = {rx_valid, rx_eop, rx_error, full}
    localparam logic [3:0] C0 = 4'b0000;
    localparam logic [3:0] V  = 4'b1000;
    localparam logic [3:0] E  = 4'b0100;
    localparam logic [3:0] ER = 4'b0010;
    localparam logic [3:0] F  = 4'b0001;

    // exp = {w_enable, w_data[7:0], pkt_done, pkt_drop, data_pkt}
    localparam logic [11:0] NONE = 12'h000;
    localparam logic [11:0] DROP = 12'h002;
    localparam logic [11:0] DPKT = 12'h001;

    function automatic logic [11:0] wr(input logic [7:0] d, input logic dn);
        return {1'b1, d, dn, 2'b00};
    endfunction

    function automatic logic [11:0] stall(input logic [7:0] d);
        return {1'b0, d, 3'b000};
    endfunction

    typedef struct packed {
        logic        rst;
        logic [7:0]  d;
        logic [3:0]  ctl;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic [7:0] d, input logic [3:0] ctl, input logic [11:0] exp);
        vec_t t;
        t.rst = rst;
        t.d   = d;
        t.ctl = ctl;
        t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic [7:0] d, input logic [3:0] ctl);
        @(posedge clk);
        #1;
        n_rst   = rst;
        rx_data = d;
        {rx_valid, rx_eop, rx_error, full} = ctl;
        @(negedge clk);
    endtask

    task automatic check(input logic [11:0] exp, input string name);
        logic [11:0] act;
        act = {w_enable, w_data, pkt_done, pkt_drop, data_pkt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {wen,wdata,done,drop,dpkt}=%b_%h_%b%b%b, expected %b_%h_%b%b%b",
                     name, act[11], act[10:3], act[2], act[1], act[0],
                     exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        int waited;
        n_rst    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_eop   = 1'b0;
        rx_error = 1'b0;
        full     = 1'b0;

        // reset state
        row(1, 8'h00, C0, NONE); row(1, 8'h00, C0, NONE); row(0, 8'h00, C0, NONE);
        // SETUP 2D 00 10: three back-to-back writes, done on the last
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h10, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h00, C0, wr(8'h2D, 0)); row(0, 8'h00, C0, wr(8'h00, 0)); row(0, 8'h00, C0, wr(8'h10, 1));
        row(0, 8'h00, C0, NONE);
        // ACK with full high for 4 cycles
        row(0, 8'hD2, V, NONE); row(0, 8'h00, E, NONE);
        for (int i = 0; i < 4; i++) row(0, 8'h00, F, stall(8'hD2));
        row(0, 8'h00, C0, wr(8'hD2, 1)); row(0, 8'h00, C0, NONE);
        // bad PID
        row(0, 8'h2E, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h10, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h00, C0, DROP); row(0, 8'h00, C0, NONE);
        // DATA0: data_pkt once, nothing else
        row(0, 8'hC3, V, NONE); row(0, 8'h11, V, DPKT); row(0, 8'h22, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h00, C0, NONE); row(0, 8'h00, C0, NONE);
        // bad CRC5
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h11, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h00, C0, DROP);
        // short token
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // rx_error mid-token: trailing byte ignored, drop at eop
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h00, ER, NONE); row(0, 8'h10, V, NONE);
        row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // special PID
        row(0, 8'h3C, V, NONE); row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // overlength token
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h10, V, NONE); row(0, 8'h10, V, NONE);
        row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // handshake with an extra byte
        row(0, 8'hD2, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // overrun during WRITE, packet still open -> discard until its eop
        row(0, 8'h2D, V, NONE); row(0, 8'h00, V, NONE); row(0, 8'h10, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h55, V, wr(8'h2D, 0)); row(0, 8'h00, C0, wr(8'h00, 0)); row(0, 8'h00, C0, wr(8'h10, 1));
        row(0, 8'h00, C0, NONE); row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        // overrun whose eop also lands during WRITE -> drop right after exit
        row(0, 8'hD2, V, NONE); row(0, 8'h00, E, NONE);
        row(0, 8'h77, V | F, stall(8'hD2)); row(0, 8'h00, E | F, stall(8'hD2));
        row(0, 8'h00, C0, wr(8'hD2, 1)); row(0, 8'h00, C0, DROP); row(0, 8'h00, C0, NONE);
        // error and stray eop in IDLE
        row(0, 8'h00, ER, NONE); row(0, 8'h00, E, NONE); row(0, 8'h00, C0, DROP);
        row(0, 8'h00, E, NONE); row(0, 8'h00, C0, NONE);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].d, vecs[i].ctl);
            check(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // reset after the first of three token writes
        drive(0, 8'h2D, V); drive(0, 8'h00, V); drive(0, 8'h10, V); drive(0, 8'h00, E);
        drive(0, 8'h00, C0); check(wr(8'h2D, 0), "rst_first_write");
        drive(1, 8'h00, C0); check(NONE, "rst_asserted");
        drive(0, 8'h00, C0); check(NONE, "rst_release");
        drive(0, 8'h00, C0); check(NONE, "rst_no_leftover");
        drive(0, 8'hD2, V);  check(NONE, "rst_ack_pid");
        drive(0, 8'h00, E);  check(NONE, "rst_ack_eop");
        waited = 0;
        drive(0, 8'h00, C0);
        while (!w_enable && waited < 8) begin
            waited++;
            drive(0, 8'h00, C0);
        end
        check(wr(8'hD2, 1), "rst_ack_write");
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL rst_ack_latency: waited %0d cycles, expected 0", waited);
        end
        drive(0, 8'h00, C0); check(NONE, "rst_ack_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nd_pkt_writer.md
ND_PKT_WRITER -- requirements
Module: nd_pkt_writer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port n_rst, input, 1, synchronous reset, asserted high.
REQ-003 SHALL have port rx_data, input, 8, received USB byte, bit 0 first on the wire.
REQ-004 SHALL have port rx_valid, input, 1, one-cycle pulse qualifying rx_data.
REQ-005 SHALL have port rx_eop, input, 1, one-cycle end-of-packet pulse, never in the same cycle as rx_valid.
REQ-006 SHALL have port rx_error, input, 1, one-cycle line/bit-stuff error pulse.
REQ-007 SHALL have port full, input, 1, full flag of the downstream non-data FIFO.
REQ-008 SHALL have port w_enable, output, 1, FIFO write strobe.
REQ-009 SHALL have port w_data, output, 8, FIFO write byte.
REQ-010 SHALL have ports pkt_done, pkt_drop and data_pkt, output, 1 each, one-cycle status pulses.

Function
REQ-011 SHALL implement states IDLE, COLLECT, WRITE and DISCARD.
REQ-012 IDLE, rx_valid: store the byte as PID in buf[0], set cnt=1; PID check fails (rx_data[3:0] != ~rx_data[7:4]) -> DISCARD with drop flag; rx_data[1:0]==2'b11 (DATA PID) -> data_pkt pulse next cycle, DISCARD with drop flag clear; rx_data[1:0]==2'b00 (special) -> DISCARD with drop flag; else -> COLLECT.
REQ-013 COLLECT, rx_valid with cnt<3: store into buf[cnt], cnt+1; with cnt==3: overlength -> DISCARD with drop flag.
REQ-014 COLLECT, rx_eop: token (PID[1:0]==2'b01) needs cnt==3 and CRC5 residual 5'b01100 over buf[1],buf[2] (LSB first, poly x^5+x^2+1, init 5'b11111); handshake (2'b10) needs cnt==1; pass -> WRITE with idx=0; fail -> pkt_drop pulse, IDLE.
REQ-015 rx_error in IDLE or COLLECT SHALL force DISCARD with drop flag set.
REQ-016 DISCARD SHALL ignore rx_valid/rx_error and on rx_eop pulse pkt_drop (if drop flag set) and return to IDLE.
REQ-017 WRITE: w_data=buf[idx]; w_enable=!full, combinational from full in the same cycle; each write increments idx; no write while full is high (stall, buffer held).
REQ-018 WRITE: the write of byte cnt-1 SHALL coincide with the pkt_done pulse; next state IDLE.
REQ-019 rx_valid seen during WRITE SHALL set an overrun flag; on WRITE exit the state SHALL be DISCARD (drop flag set), or IDLE with a pkt_drop pulse if rx_eop was also seen during WRITE.
REQ-020 w_enable SHALL be 0 outside WRITE; w_data SHALL be 8'h00 outside WRITE.
REQ-021 Packet latency: first write SHALL occur the cycle after rx_eop when full is low; a 3-byte token completes in 3 cycles.
REQ-022 Each byte SHALL be written exactly once; no partial packet SHALL ever reach the FIFO.

Reset
REQ-023 n_rst high at a clock edge SHALL force IDLE, cnt=0, idx=0, all flags 0 and all outputs 0, including mid-WRITE (remaining bytes discarded).
REQ-024 After reset release the first accepted packet SHALL start at the next rx_valid.

Structure
REQ-025 Package nd_pkg SHALL hold the state enum, PID type codes (2'b01 token, 2'b10 handshake, 2'b11 data, 2'b00 special) and CRC5 residual constant 5'b01100.
REQ-026 CRC5 check SHALL be a sub-module nd_crc5 (16-bit combinational input, residual_ok output).
REQ-027 Output SHALL connect directly to nd_fifo write side (w_enable, w_data, full).

Verification
REQ-028 SETUP bytes 2D,00,10 then eop, full=0 -> writes 2D,00,10 on 3 consecutive cycles, pkt_done with the third write.
REQ-029 ACK D2 then eop, full held high 4 cycles -> no write for 4 cycles, then single write D2 with pkt_done.
REQ-030 Bad PID 2E,00,10 then eop -> no writes, pkt_drop once at eop; DATA0 C3,xx,xx,eop -> data_pkt once, no pkt_drop, no writes.
REQ-031 SETUP 2D,00,11 (bad CRC5) or 2D,00 (short) then eop -> pkt_drop, no writes; rx_error mid-token -> pkt_drop at eop.
REQ-032 n_rst high after first of 3 token writes -> w_enable 0 next cycle, state IDLE, next ACK D2 written normally.
